// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiplier FSM encoding and default widths.
package mips_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_unit.sv
// Iterative shift-add hi/lo multiplier for mult/multu; works on magnitudes and
// fixes the sign of the 2*WIDTH product in a final cycle.
module mult_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic [WIDTH:0]       sum;

    // -2^(WIDTH-1) negates to itself, which is already the right unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] x);
        return -x;
    endfunction

    // Carry out of the upper half is kept and becomes the MSB after the shift.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_mult) begin
                        sign_a <= mult_sign & srca[WIDTH-1];
                        sign_b <= mult_sign & srcb[WIDTH-1];
                        mcand  <= magnitude(srca, mult_sign & srca[WIDTH-1]);
                        mplier <= magnitude(srcb, mult_sign & srcb[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    {hi, lo} <= (sign_a ^ sign_b) ? negate(acc) : acc;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
